pe_reduce: RTL
==============

Name: pe_reduce

Overview:
- Downstream consumer of the vector add/sub PE stage. Takes a full result vector (NoOfElem lanes of wordSize bits) per beat and sums all lanes through a pipelined binary adder tree.
- Optionally accumulates consecutive beats into one scalar, delimited by a last flag.
- Presents the scalar on a valid/ready output toward writeback / the scalar register file.

Parameters:
- NoOfElem, 16, lanes per input vector; power of two, >= 2
- wordSize, 32, bits per lane; lanes are signed two's complement
- GUARD, 8, extra accumulator/output bits; OUT_W = wordSize + GUARD, GUARD >= clog2(NoOfElem)

Ports:
- clk  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector beat present
- in_ready  out  1  block can accept a beat this cycle
- in_vec  in  NoOfElem x wordSize  packed vector; lane i = in_vec[i]
- in_last  in  1  final beat of an accumulation group; tie 1 for per-vector sums
- out_valid  out  1  scalar result present
- out_ready  in  1  consumer accepts the result
- out_sum  out  OUT_W  signed group sum
- out_count  out  8  number of beats in the group (saturates at 255)
- out_ovf  out  1  signed overflow occurred anywhere in the group

Behaviour:
- Reset (RESET=1, asynchronous assert, released synchronously to clk):
  - All pipeline valid bits = 0, out_valid = 0, out_sum = 0, out_count = 0, out_ovf = 0.
  - Accumulator = 0, beat counter = 0, sticky overflow = 0.
  - Reset mid-operation discards all in-flight beats and any partial group.
- Pipeline enable: en = !out_valid || out_ready. The whole pipeline advances only when en = 1.
  - in_ready = en, combinational; the design is purely registered otherwise.
  - Bubbles are not compressed during a stall.
- Stage 0: when in_valid && in_ready, register in_vec and in_last, and set v0 = 1. When en = 1 and no input is accepted, v0 = 0.
- Tree levels 1..L, where L = clog2(NoOfElem):
  - Level k registers NoOfElem/2^k partial sums, each the sum of two level-(k-1) entries.
  - Each operand is sign-extended to OUT_W before addition.
  - The valid bit and last flag travel with the data.
- Accumulate stage, on en && vL:
  - s = acc + treeL, computed modulo 2^OUT_W.
  - ovf_now = (sign(acc) == sign(treeL)) && (sign(s) != sign(acc)).
  - cnt_next = min(cnt + 1, 255).
  - If lastL: out_sum <= s, out_count <= cnt_next, out_ovf <= ovfsticky | ovf_now, out_valid <= 1. Then acc <= 0, cnt <= 0, ovfsticky <= 0.
  - Else: acc <= s, cnt <= cnt_next, ovfsticky <= ovfsticky | ovf_now. out_valid <= 0 if out_ready was high, otherwise held.
- Output handshake: a transfer occurs when out_valid && out_ready.
  - out_sum, out_count and out_ovf hold stable while out_valid && !out_ready.
  - out_valid deasserts the cycle after a transfer unless a new last beat completes in the same cycle; back-to-back results are allowed.
- Latency: with no stall, a last beat accepted at edge N gives out_valid = 1 after edge N+L+1 (edge N+5 for NoOfElem = 16). Throughput is 1 beat/cycle.
- Simultaneous events:
  - A new input is accepted in the same cycle as an output transfer.
  - The accumulator clear and the next group's first beat can land together; the next group starts from 0.
- Lane sums are exact: L <= GUARD, so the tree never overflows. out_ovf reflects accumulation overflow only.

Test Plan:
- Reset, then one beat with lanes 1..16 and in_last = 1 -> out_valid after 5 cycles; out_sum = 136, out_count = 1, out_ovf = 0.
- Group of 3 beats (all lanes 1, all lanes 2, all lanes -1; last on the third) -> one result: out_sum = 32, out_count = 3. No out_valid on beats 1 and 2.
- Two independent last beats on consecutive cycles with out_ready held 0 for 4 cycles:
  - First result holds stable and in_ready = 0 during the stall.
  - After release, results come out in order with no loss or duplication.
- All lanes 0x7FFFFFFF, groups of 256 beats (wordSize = 32, GUARD = 8) -> accumulator wraps; out_ovf = 1 and out_count = 255 (saturated).
- All lanes 0x80000000, single beat -> out_sum = -2^35 as a 40-bit value (0xF800000000), out_ovf = 0.
- Assert RESET while 2 beats of a group are in flight, deassert, then send one last beat of all lanes 3 -> out_sum = 48, out_count = 1. No stale partial sum.

Source files
------------

// File: rtl/pe_reduce_if.sv
// pe_reduce handshake bundle: vector beats in, scalar sums out.
// master drives beats and out_ready; slave is the reducer.
interface pe_reduce_if #(
  parameter int NoOfElem = 16,
  parameter int wordSize = 32,
  parameter int GUARD    = 8
);
  localparam int OUT_W = wordSize + GUARD;

  logic                               in_valid;
  logic                               in_ready;
  logic [NoOfElem-1:0][wordSize-1:0]  in_vec;
  logic                               in_last;
  logic                               out_valid;
  logic                               out_ready;
  logic [OUT_W-1:0]                   out_sum;
  logic [7:0]                         out_count;
  logic                               out_ovf;

  modport master (
    output in_valid, in_vec, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_vec, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/pe_reduce.sv
// Lane-sum reducer: pipelined adder tree plus grouped
// accumulation with sticky overflow, valid/ready scalar output.
module pe_reduce #(
  parameter int NoOfElem = 16,
  parameter int wordSize = 32,
  parameter int GUARD    = 8
) (
  input logic       clk,
  input logic       RESET,
  pe_reduce_if.slave bus
);
  localparam int L     = $clog2(NoOfElem);
  localparam int OUT_W = wordSize + GUARD;

  logic             en;
  logic             out_valid;
  logic [OUT_W-1:0] out_sum;
  logic [7:0]       out_count;
  logic             out_ovf;
  logic [OUT_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovfs;
  logic [OUT_W-1:0] tl;
  logic [OUT_W-1:0] s;
  logic             ovf_now;
  logic [7:0]       cnt_next;
  logic             vl;
  logic             ll;

  // Whole pipeline moves together; stalls only on a held result.
  assign en           = !out_valid || bus.out_ready;
  assign bus.in_ready = en;

  genvar k;
  generate
    for (k = 0; k <= L; k++) begin : lv
      localparam int N = NoOfElem >> k;
      logic [N*OUT_W-1:0] d;
      logic               v;
      logic               l;
      if (k == 0) begin : g_in
        logic [N*OUT_W-1:0] ext;
        // Sign-extend every lane to the full result width.
        always_comb begin
          ext = '0;
          for (int i = 0; i < N; i++) begin
            ext[i*OUT_W +: OUT_W] =
              {{GUARD{bus.in_vec[i][wordSize-1]}},
               bus.in_vec[i]};
          end
        end
        // Capture an accepted beat; insert a bubble otherwise.
        always_ff @(posedge clk or posedge RESET) begin
          if (RESET) begin
            d <= '0;
            v <= 1'b0;
            l <= 1'b0;
          end else if (en) begin
            v <= bus.in_valid;
            if (bus.in_valid) begin
              d <= ext;
              l <= bus.in_last;
            end
          end
        end
      end else begin : g_add
        logic [N*OUT_W-1:0] sum;
        // Pairwise sums of the previous level.
        always_comb begin
          sum = '0;
          for (int j = 0; j < N; j++) begin
            sum[j*OUT_W +: OUT_W] =
              lv[k-1].d[(2*j)*OUT_W +: OUT_W] +
              lv[k-1].d[(2*j+1)*OUT_W +: OUT_W];
          end
        end
        // Register the level; valid and last ride along.
        always_ff @(posedge clk or posedge RESET) begin
          if (RESET) begin
            d <= '0;
            v <= 1'b0;
            l <= 1'b0;
          end else if (en) begin
            d <= sum;
            v <= lv[k-1].v;
            l <= lv[k-1].l;
          end
        end
      end
    end
  endgenerate

  assign tl = lv[L].d;
  assign vl = lv[L].v;
  assign ll = lv[L].l;

  assign s        = acc + tl;
  assign ovf_now  = (acc[OUT_W-1] == tl[OUT_W-1]) &&
                    (s[OUT_W-1] != acc[OUT_W-1]);
  assign cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // Fold tree results into the group; publish on the last beat.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      acc       <= '0;
      cnt       <= '0;
      ovfs      <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      if (vl && ll) begin
        out_sum   <= s;
        out_count <= cnt_next;
        out_ovf   <= ovfs | ovf_now;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        ovfs      <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        if (vl) begin
          acc  <= s;
          cnt  <= cnt_next;
          ovfs <= ovfs | ovf_now;
        end
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_count = out_count;
  assign bus.out_ovf   = out_ovf;
endmodule
